axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Parametrised AXI3 read-channel front end serving NUM_CH cache/uncached requestors; successor to the fixed two-port I/D read arbitration in the cache-to-AXI bridge.
- Round-robin grant with a registered AR stage.
- Multiple reads outstanding, one per channel, tagged by ARID = channel index; R beats routed back by RID.
- Gated by the write engine's idle flag to preserve read-after-write ordering.

Parameters:
- NUM_CH, 2, number of requestor channels (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, R data width.
- ID_W, 4, AXI ID width; must satisfy 2^ID_W >= NUM_CH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_CH  per-channel read request
- req_ready  out  NUM_CH  one-hot accept pulse; the request is latched this cycle
- req_addr  in  NUM_CH*ADDR_W  byte address, channel c at [c*ADDR_W +: ADDR_W]
- req_size  in  NUM_CH*2  single-beat size (0=byte, 1=half, 2=word)
- req_burst  in  NUM_CH  1 = INCR line fill, 0 = single FIXED beat
- req_len  in  NUM_CH*8  burst length minus 1; used only when req_burst=1
- ret_valid  out  NUM_CH  per-channel R beat valid
- ret_last  out  NUM_CH  per-channel last beat
- ret_data  out  DATA_W  shared R data, valid for the channel with ret_valid set
- wr_idle  in  1  write engine idle; no new grant while low
- rd_busy  out  1  OR of AR pending and all outstanding flags (feeds write engine)
- arid  out  ID_W  AR channel ID
- araddr  out  ADDR_W  AR address
- arlen  out  8  AR burst length
- arsize  out  3  AR beat size
- arburst  out  2  AR burst type
- arlock  out  2  AR lock
- arcache  out  4  AR cache
- arprot  out  3  AR protection
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  ID_W  R channel ID
- rdata  in  DATA_W  R data
- rresp  in  2  R response
- rlast  in  1  R last beat
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Reset: arvalid=0, req_ready=0, ret_valid=0, ret_last=0, all outstanding flags 0, RR pointer=0. rready is a constant 1. arlock, arcache and arprot are constant 0.
- Eligible[c] = req_valid[c] & ~outstanding[c] & ~(arvalid & arid==c).
- Grant:
  - Condition: ~arvalid | (arvalid & arready) (the AR register is free or freeing), wr_idle=1, and any channel eligible.
  - Selection: first eligible channel at or after the RR pointer, wrapping modulo NUM_CH.
  - Same cycle: req_ready[g]=1.
  - Next cycle: arvalid=1, arid=g, araddr=req_addr[g].
  - If req_burst[g]: arburst=INCR, arlen=req_len[g], arsize=3'b010. Else: arburst=FIXED, arlen=0, arsize={1'b0,req_size[g]}.
  - RR pointer becomes g+1, wrapping at NUM_CH.
- Requestor obligations: hold request fields stable until req_ready.
- AR hold: all AR outputs are held stable while arvalid & ~arready.
- AR handshake (arvalid & arready): outstanding[arid] <= 1. A back-to-back grant in the same cycle is allowed (pipelined AR).
- R routing, combinational:
  - ret_valid[c] = rvalid & (rid==c); ret_last[c] = rlast & (rid==c); ret_data = rdata.
  - rvalid & rlast & rid==c clears outstanding[c].
  - A clear and a new handshake on the same channel in the same cycle cannot occur, because eligibility excludes it.
- Unknown RID (rid >= NUM_CH, or the addressed channel has no outstanding read): beat accepted and dropped, no ret_valid.
- rresp is ignored.
- wr_idle falling while arvalid=1: the pending AR still completes; only new grants are blocked.
- Reset mid-burst: all state cleared; stale R beats after reset are dropped by the outstanding check.
- Latency: req_valid to arvalid is 1 cycle; rvalid to ret_valid is 0 cycles.

Optional Feature:
- AXI_RD_FIXED_PRIO_EN defined: fixed priority, lowest eligible index wins, RR pointer removed.
- Undefined: round-robin as above.

Decomposition:
- Shared package axi_pkg: BURST_FIXED=2'b00, BURST_INCR=2'b01, SIZE_WORD=3'b010, AR beat struct {id, addr, len, size, burst}.
- One sub-module, rr_picker: NUM_CH-wide eligible vector plus pointer in, one-hot grant plus index out. It holds the fixed-priority path under the macro.

Test Plan:
- Single burst: NUM_CH=2, ch1 req addr=0x1000, burst=1, len=3 -> arvalid next cycle with arid=1, arlen=3, arsize=2, arburst=01; 4 R beats rid=1 give ret_valid[1] x4 with ret_last on the 4th; outstanding[1] cleared.
- Fairness: ch0 and ch1 requesting continuously, arready=1, R returned immediately -> grants alternate 0,1,0,1. With AXI_RD_FIXED_PRIO_EN: ch0 wins whenever eligible.
- Write gate: wr_idle=0 while ch0 requests -> no req_ready and no arvalid; wr_idle=1 -> grant in that cycle.
- AR backpressure: arready=0 for 5 cycles -> araddr/arlen/arid stable, no new req_ready; arready=1 -> outstanding set, next grant in the same cycle.
- Interleaved R: ch0 and ch1 both outstanding, R beats rid=1,0,1 -> ret_valid follows rid exactly; rid=3 beat dropped.
- Reset: assert reset during a burst -> next cycle all outputs at reset values; a subsequent request is issued normally.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI3 read-channel constants and the AR attribute type.
//
// The AR attribute struct carries the fixed-width part of an AR beat
// (len/size/burst). The id/addr part depends on module parameters, so each
// user wraps ar_attr_t into its own parameterised beat struct.
//
// ar_attr() maps a requestor's (line_fill, size, len) onto AXI attributes:
// - Line fills become INCR word bursts of len+1 beats.
// - Single accesses become one FIXED beat of the requested size.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_attr_t;

  function automatic ar_attr_t ar_attr(input logic       line_fill,
                                       input logic [1:0] size,
                                       input logic [7:0] len);
    ar_attr_t a;
    if (line_fill) begin
      a.len   = len;
      a.size  = SIZE_WORD;
      a.burst = BURST_INCR;
    end else begin
      a.len   = 8'd0;
      a.size  = {1'b0, size};
      a.burst = BURST_FIXED;
    end
    return a;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: AXI3 read address (AR) and read data (R) channels.
//
// Modports:
//   master - drives AR and rready (the arbiter side)
//   slave  - drives arready and the R channel (the interconnect/memory side)
interface axi_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/rr_picker.sv
// rr_picker: picks one channel from an eligible vector.
//
// Ports:
//   ptr       - round-robin start index (absent with AXI_RD_FIXED_PRIO_EN)
//   eligible  - per-channel candidate vector
//   grant     - one-hot winner (all zero when nothing eligible)
//   grant_idx - binary index of the winner
//   any       - at least one channel eligible
//
// Macro AXI_RD_FIXED_PRIO_EN: lowest eligible index wins and the pointer
// input disappears. Default: first eligible index at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IDX_W  = 1
) (
`ifndef AXI_RD_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]  ptr,
`endif
  input  logic [NUM_CH-1:0] eligible,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
`ifndef AXI_RD_FIXED_PRIO_EN
    // First pass covers [ptr, NUM_CH); the fallback pass below supplies the
    // wrapped part [0, ptr) because it only fires when this one found nothing.
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!any && eligible[c] && (c >= 32'(ptr))) begin
        any       = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = IDX_W'(c);
      end
    end
`endif
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!any && eligible[c]) begin
        any       = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: AXI3 read front end for NUM_CH requestor channels.
//
// One AR register is shared by all channels; a new grant loads it when it is
// empty or being accepted this cycle, so ARs can issue back to back. Each
// channel may have one read outstanding, tagged ARID = channel index, and R
// beats are steered back by RID. No grant is made while wr_idle is low so a
// read can never overtake a write still in the write engine.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req_*               - per-channel request (valid/addr/size/burst/len),
//                         req_ready is a one-hot accept pulse
//   ret_valid/last/data - per-channel R beat return (data is shared)
//   wr_idle             - write engine idle; gates new grants
//   rd_busy             - AR pending or any read outstanding
//   axi                 - AR/R channels (master modport)
//
// Macro AXI_RD_FIXED_PRIO_EN: fixed priority (lowest index) instead of
// round-robin; the RR pointer is not built.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*2-1:0]      req_size,
  input  logic [NUM_CH-1:0]        req_burst,
  input  logic [NUM_CH*8-1:0]      req_len,
  output logic [NUM_CH-1:0]        ret_valid,
  output logic [NUM_CH-1:0]        ret_last,
  output logic [DATA_W-1:0]        ret_data,
  input  logic                     wr_idle,
  output logic                     rd_busy,
  axi_rd_arbiter_if.master         axi
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    ar_attr_t          attr;
  } ar_beat_t;

  // State
  logic              ar_valid_q, ar_valid_d;
  ar_beat_t          ar_q, ar_d;
  logic [NUM_CH-1:0] outstanding_q, outstanding_d;
`ifndef AXI_RD_FIXED_PRIO_EN
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
`endif

  // Decode
  logic              ar_fire;
  logic              ar_free;
  logic              grant_en;
  logic [NUM_CH-1:0] ar_hit;     // channel owning the pending AR
  logic [NUM_CH-1:0] r_hit;      // R beat addresses a channel with a read in flight
  logic [NUM_CH-1:0] r_done;     // last beat of that read
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic              sel_burst;
  logic [7:0]        sel_len;

  assign ar_fire = ar_valid_q & axi.arready;
  assign ar_free = ~ar_valid_q | axi.arready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ar_hit[c]   = ar_valid_q & (ar_q.id == ID_W'(c));
    // Gating with outstanding drops stale beats (e.g. after reset) and beats
    // for channels that never issued a read.
    assign r_hit[c]    = axi.rvalid & (axi.rid == ID_W'(c)) & outstanding_q[c];
    assign r_done[c]   = r_hit[c] & axi.rlast;
    assign eligible[c] = req_valid[c] & ~outstanding_q[c] & ~ar_hit[c];
  end

  rr_picker #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_picker (
`ifndef AXI_RD_FIXED_PRIO_EN
    .ptr       (rr_ptr_q),
`endif
    .eligible  (eligible),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign grant_en = ar_free & wr_idle & pick_any;

  // Request field mux for the winning channel.
  always_comb begin
    sel_addr  = '0;
    sel_size  = '0;
    sel_burst = 1'b0;
    sel_len   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (pick_grant[c]) begin
        sel_addr  = req_addr[c*ADDR_W +: ADDR_W];
        sel_size  = req_size[c*2 +: 2];
        sel_burst = req_burst[c];
        sel_len   = req_len[c*8 +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_valid_q    <= 1'b0;
      ar_q          <= '0;
      outstanding_q <= '0;
`ifndef AXI_RD_FIXED_PRIO_EN
      rr_ptr_q      <= '0;
`endif
    end else begin
      ar_valid_q    <= ar_valid_d;
      ar_q          <= ar_d;
      outstanding_q <= outstanding_d;
`ifndef AXI_RD_FIXED_PRIO_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end

  // Next state
  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_d       = ar_q;
`ifndef AXI_RD_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif

    if (ar_fire) begin
      ar_valid_d = 1'b0;
    end
    // A grant while the current AR is accepted reloads the register directly.
    if (grant_en) begin
      ar_valid_d = 1'b1;
      ar_d.id    = ID_W'(pick_idx);
      ar_d.addr  = sel_addr;
      ar_d.attr  = ar_attr(sel_burst, sel_size, sel_len);
`ifndef AXI_RD_FIXED_PRIO_EN
      rr_ptr_d   = (pick_idx == IDX_W'(NUM_CH - 1)) ? '0 : pick_idx + IDX_W'(1);
`endif
    end

    // Clear and set never hit the same channel: a channel with a read in
    // flight is not eligible, so it cannot own the AR being accepted.
    outstanding_d = outstanding_q & ~r_done;
    if (ar_fire) begin
      outstanding_d = outstanding_d | ar_hit;
    end
  end

  // Outputs
  always_comb begin
    req_ready   = grant_en ? pick_grant : '0;
    ret_valid   = r_hit;
    ret_last    = r_done;
    ret_data    = axi.rdata;
    rd_busy     = ar_valid_q | (|outstanding_q);

    axi.arvalid = ar_valid_q;
    axi.arid    = ar_q.id;
    axi.araddr  = ar_q.addr;
    axi.arlen   = ar_q.attr.len;
    axi.arsize  = ar_q.attr.size;
    axi.arburst = ar_q.attr.burst;
    axi.arlock  = 2'b00;
    axi.arcache = 4'b0000;
    axi.arprot  = 3'b000;
    axi.rready  = 1'b1;
  end

  // rresp carries no routing information; errors are not reported upstream.
  logic unused_rresp;
  assign unused_rresp = ^axi.rresp;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: randomized scoreboard bench for axi_rd_arbiter.
// A stimulus process drives requestors, wr_idle and an AXI slave, runs a
// reference model of the arbitration rules and queues expected results; a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_axi_rd_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*2-1:0]    req_size = '0;
  logic [N-1:0]      req_burst = '0;
  logic [N*8-1:0]    req_len = '0;
  logic [N-1:0]      ret_valid;
  logic [N-1:0]      ret_last;
  logic [DW-1:0]     ret_data;
  logic              wr_idle = 1'b1;
  logic              rd_busy;

  axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) axi ();

  axi_rd_arbiter #(
    .NUM_CH (N),
    .ADDR_W (AW),
    .DATA_W (DW),
    .ID_W   (IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_burst (req_burst),
    .req_len   (req_len),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data),
    .wr_idle   (wr_idle),
    .rd_busy   (rd_busy),
    .axi       (axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [N-1:0] rr;
    bit         arv;
    bit         busy;
  } cyc_t;
  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;
  typedef struct {
    int          ch;
    logic [31:0] data;
    bit          last;
  } ret_t;

  cyc_t cyc_q[$];
  ar_t  ar_q[$];
  ret_t ret_q[$];

  int total = 0;
  int bad = 0;

  // Requestors
  bit          rq_v[N];
  logic [31:0] rq_addr[N];
  logic [1:0]  rq_size[N];
  bit          rq_burst[N];
  logic [7:0]  rq_len[N];

  // Reference model state
  bit [N-1:0] m_out;
  bit         m_arv;
  int         m_arid;
  int         m_arlen;
  int         m_ptr;
  int         sl_rem[N];  // beats the slave still owes per channel

  // Knobs (percent)
  int p_req = 0, p_ar = 100, p_rv = 100, p_junk = 0, p_wi = 100;
  bit auto_req = 1'b0;
  bit rst_now = 1'b1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_out  = '0;
    m_arv  = 1'b0;
    m_arid = 0;
    m_arlen = 0;
    m_ptr  = 0;
    for (int c = 0; c < N; c++) sl_rem[c] = 0;
    ar_q.delete();
  endfunction

  task automatic cycle();
    int   live[$];
    int   g, c, r;
    bit   hs;
    ar_t  a;
    @(posedge clk);
    #1;
    reset = rst_now;
    if (auto_req) begin
      for (int k = 0; k < N; k++) begin
        if (!rq_v[k] && ($urandom_range(99) < p_req)) begin
          rq_v[k]     = 1'b1;
          rq_addr[k]  = $urandom;
          rq_burst[k] = bit'($urandom_range(1));
          rq_size[k]  = 2'($urandom_range(2));
          rq_len[k]   = rq_burst[k] ? 8'($urandom_range(7)) : 8'($urandom);
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      req_valid[k]          = rq_v[k];
      req_addr[k*AW +: AW]  = rq_addr[k];
      req_size[k*2 +: 2]    = rq_size[k];
      req_burst[k]          = rq_burst[k];
      req_len[k*8 +: 8]     = rq_len[k];
    end
    wr_idle     = ($urandom_range(99) < p_wi);
    axi.arready = ($urandom_range(99) < p_ar);

    // Slave: either a beat of a live read, or a junk beat that must be dropped
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rid    = '0;
    axi.rdata  = $urandom;
    axi.rresp  = 2'($urandom);
    for (int k = 0; k < N; k++) if (sl_rem[k] > 0) live.push_back(k);
    if ($urandom_range(99) < p_rv) begin
      axi.rvalid = 1'b1;
      if (live.size() == 0 || ($urandom_range(99) < p_junk)) begin
        axi.rlast = 1'($urandom_range(1));
        r = N;
        if ($urandom_range(1) == 1) r = $urandom_range(15, N);
        else for (int k = 0; k < N; k++) if (sl_rem[k] == 0 && $urandom_range(1) == 1) r = k;
        axi.rid = IW'(r);
      end else begin
        c = live[$urandom_range(live.size() - 1)];
        axi.rid   = IW'(c);
        axi.rlast = (sl_rem[c] == 1);
        if (!reset) sl_rem[c]--;
      end
    end

    if (reset) begin
      model_reset();
      return;
    end

    // Arbitration rules: AR slot free or freeing, writes idle, first eligible
    // channel at or after the pointer.
    hs = m_arv && axi.arready;
    g = -1;
    if ((!m_arv || axi.arready) && wr_idle) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (g < 0 && rq_v[c] && !m_out[c] && !(m_arv && m_arid == c)) g = c;
      end
    end
    cyc_q.push_back('{rr: (g >= 0) ? N'(1 << g) : '0, arv: m_arv, busy: m_arv || (|m_out)});

    r = int'(axi.rid);
    if (axi.rvalid && r < N && m_out[r]) begin
      ret_q.push_back('{ch: r, data: axi.rdata, last: axi.rlast});
      if (axi.rlast) m_out[r] = 1'b0;
    end

    if (hs) begin
      m_out[m_arid]  = 1'b1;
      sl_rem[m_arid] = m_arlen + 1;
    end

    if (g >= 0) begin
      a.id    = g;
      a.addr  = rq_addr[g];
      a.len   = rq_burst[g] ? rq_len[g] : 8'd0;
      a.size  = rq_burst[g] ? 3'd2 : {1'b0, rq_size[g]};
      a.burst = rq_burst[g] ? 2'b01 : 2'b00;
      ar_q.push_back(a);
      m_arv   = 1'b1;
      m_arid  = g;
      m_arlen = int'(a.len);
`ifdef AXI_RD_FIXED_PRIO_EN
      m_ptr   = 0;
`else
      m_ptr   = (g + 1) % N;
`endif
      rq_v[g] = 1'b0;
    end else if (hs) begin
      m_arv = 1'b0;
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    cyc_t e;
    ar_t  a;
    ret_t rt;
    if (!reset && cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("req_ready", req_ready, e.rr);
      chk("arvalid", axi.arvalid, e.arv);
      chk("rd_busy", rd_busy, e.busy);
      chk("rready", axi.rready, 1);
      if (axi.arvalid) begin
        if (ar_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ar_unexpected: got arid %0d with no AR expected", axi.arid);
        end else begin
          a = ar_q[0];
          chk("arid", axi.arid, a.id);
          chk("araddr", axi.araddr, a.addr);
          chk("arlen", axi.arlen, a.len);
          chk("arsize", axi.arsize, a.size);
          chk("arburst", axi.arburst, a.burst);
          chk("ar_lock_cache_prot", {axi.arlock, axi.arcache, axi.arprot}, 0);
          if (axi.arready) void'(ar_q.pop_front());
        end
      end
      if (ret_q.size() > 0) begin
        rt = ret_q.pop_front();
        chk("ret_valid", ret_valid, 1 << rt.ch);
        chk("ret_last", ret_last, rt.last ? (1 << rt.ch) : 0);
        chk("ret_data", ret_data, rt.data);
      end else begin
        chk("ret_valid_idle", ret_valid, 0);
      end
    end
  end

  initial begin
    int n;
    for (int k = 0; k < N; k++) begin
      rq_v[k] = 0; rq_addr[k] = 0; rq_size[k] = 0; rq_burst[k] = 0; rq_len[k] = 0;
    end
    model_reset();
    axi.arready = 1'b0;
    axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;

    rst_now = 1'b1;
    repeat (3) cycle();
    rst_now = 1'b0;

    // Single INCR burst on ch1
    auto_req = 1'b0;
    rq_v[1] = 1'b1; rq_addr[1] = 32'h1000; rq_burst[1] = 1'b1; rq_len[1] = 8'd3;
    rq_size[1] = 2'd0;
    p_ar = 100; p_rv = 100; p_junk = 0; p_wi = 100;
    repeat (12) cycle();

    // Both channels always requesting, immediate AR/R
    auto_req = 1'b1; p_req = 100;
    repeat (40) cycle();

    // Write gate closed, then opened
    p_wi = 0;
    repeat (10) cycle();
    p_wi = 100;
    repeat (8) cycle();

    // AR backpressure
    p_ar = 0;
    repeat (6) cycle();
    p_ar = 100;
    repeat (8) cycle();

    // Random mix with interleaved R and junk beats
    p_req = 60; p_ar = 60; p_rv = 60; p_junk = 25; p_wi = 80;
    repeat (600) cycle();

    // Reset in the middle of traffic, then carry on
    rst_now = 1'b1;
    cycle();
    rst_now = 1'b0;
    repeat (300) cycle();

    // Drain
    auto_req = 1'b0; p_ar = 100; p_rv = 100; p_junk = 0; p_wi = 100;
    n = 0;
    while ((m_arv || (|m_out) || rq_v[0] || rq_v[1]) && n < 2000) begin
      cycle();
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: traffic still pending after %0d cycles", n);
    end
    repeat (3) cycle();
    @(posedge clk);
    chk("ar_left", ar_q.size(), 0);
    chk("ret_left", ret_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
